// File: rtl/l1d_wb_pkg.sv
// rtl/l1d_wb_pkg.sv - shared types and sizing for the L1D write-back buffer
package l1d_wb_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_PTR_W  = $clog2(WB_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_RD_MEM = 3'd2,
        ST_WR_MEM = 3'd3,
        ST_RESP   = 3'd4
    } wb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_store.sv
// rtl/wb_entry_store.sv - FIFO-ordered entry array with parallel address match
module wb_entry_store #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              alloc_i,
    input  logic              coalesce_i,
    input  logic              pop_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] match_data_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q, match_idx;
    logic [PTR_W:0]    count_q, count_d;
    logic              empty_q;
    logic [DEPTH-1:0]  match_vec;

    // Coalescing guarantees at most one bit of match_vec is set.
    always_comb begin
        hit_o        = 1'b0;
        match_idx    = '0;
        match_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] && (addr_q[i] == lookup_addr_i);
            if (match_vec[i]) begin
                hit_o        = 1'b1;
                match_idx    = PTR_W'(i);
                match_data_o = data_q[i];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (alloc_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !alloc_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (alloc_i) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= lookup_addr_i;
                data_q[tail_q]  <= wdata_i;
                tail_q          <= tail_q + 1'b1;
            end
            if (coalesce_i) begin
                data_q[match_idx] <= wdata_i;
            end
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = empty_q;

endmodule

// File: rtl/l1d_write_buffer.sv
// rtl/l1d_write_buffer.sv - coalescing write-back buffer between L1D and main memory
module l1d_write_buffer
    import l1d_wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_request,
    input  logic              c_write_enable,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [DATA_W-1:0] c_write_data,
    output logic [DATA_W-1:0] c_response_data,
    output logic              c_ready,
    input  logic              flush,
    output logic              empty,
    output logic              mem_request,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_response_data,
    input  logic              mem_ready
);

    wb_state_t         state_q, state_d;
    logic              c_ready_q, c_ready_d;
    logic [DATA_W-1:0] c_resp_q, c_resp_d, fwd_data_q, fwd_data_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              alloc, coalesce, pop;
    logic              hit, full, store_empty;
    logic [DATA_W-1:0] match_data, head_data;
    logic [ADDR_W-1:0] head_addr;

    wb_entry_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_store (
        .clk          (clk),
        .reset        (reset),
        .lookup_addr_i(c_address),
        .wdata_i      (c_write_data),
        .alloc_i      (alloc),
        .coalesce_i   (coalesce),
        .pop_i        (pop),
        .hit_o        (hit),
        .match_data_o (match_data),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .full_o       (full),
        .empty_o      (store_empty)
    );

    always_comb begin
        state_d     = state_q;
        c_ready_d   = 1'b0;
        c_resp_d    = '0;
        fwd_data_d  = fwd_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        alloc       = 1'b0;
        coalesce    = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The c_ready cycle is left quiet so a back-to-back request
                // is taken before a background drain can claim memory.
                if (c_ready_q) begin
                    state_d = ST_IDLE;
                end else if (c_request && !flush && c_write_enable && hit) begin
                    coalesce = 1'b1;
                    state_d  = ST_RESP;
                end else if (c_request && !flush && c_write_enable && !full) begin
                    alloc   = 1'b1;
                    state_d = ST_RESP;
                end else if (c_request && !flush && !c_write_enable && hit) begin
                    fwd_data_d = match_data;
                    state_d    = ST_FWD;
                end else if (c_request && !flush && !c_write_enable) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = c_address;
                    state_d    = ST_RD_MEM;
                end else if (!store_empty) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                    state_d     = ST_WR_MEM;
                end
            end
            ST_FWD: begin
                c_ready_d = 1'b1;
                c_resp_d  = fwd_data_q;
                state_d   = ST_IDLE;
            end
            ST_RESP: begin
                c_ready_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD_MEM: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    c_ready_d = 1'b1;
                    c_resp_d  = mem_response_data;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_MEM: begin
                if (mem_ready) begin
                    pop       = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            c_ready_q   <= 1'b0;
            c_resp_q    <= '0;
            fwd_data_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            c_ready_q   <= c_ready_d;
            c_resp_q    <= c_resp_d;
            fwd_data_q  <= fwd_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign c_ready          = c_ready_q;
    assign c_response_data  = c_resp_q;
    assign empty            = store_empty;
    assign mem_request      = mem_req_q;
    assign mem_write_enable = mem_we_q;
    assign mem_address      = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_l1d_write_buffer.sv
// tb/tb_l1d_write_buffer.sv - scoreboard bench for l1d_write_buffer
module tb_l1d_write_buffer;
    import l1d_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_request, c_write_enable, flush;
    logic [31:0] c_address, c_write_data, c_response_data;
    logic        c_ready, empty;
    logic        mem_request, mem_write_enable, mem_ready;
    logic [31:0] mem_address, mem_write_data, mem_response_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_resp = 0;
    int last_ready_cyc = -10;
    int mem_lat, lat_cnt, stray_req, stray_done, n0, n;
    bit mem_stall;
    logic [31:0] mem_rd_value;

    logic [31:0] exp_resp[$];
    logic [31:0] exp_rd[$];
    wb_entry_t   exp_wr[$];

    l1d_write_buffer dut (
        .clk(clk), .reset(reset),
        .c_request(c_request), .c_write_enable(c_write_enable),
        .c_address(c_address), .c_write_data(c_write_data),
        .c_response_data(c_response_data), .c_ready(c_ready),
        .flush(flush), .empty(empty),
        .mem_request(mem_request), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_response_data(mem_response_data), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Cache-side monitor
    initial forever begin
        @(negedge clk);
        if (c_ready === 1'b1) begin
            n_resp++;
            if (exp_resp.size() == 0) check("unexpected_c_ready", 1, 0);
            else check("c_response_data", c_response_data, exp_resp.pop_front());
        end
    end

    // Memory model and memory-side monitor
    initial begin
        mem_ready = 1'b0;
        mem_response_data = '0;
        lat_cnt = 0;
        stray_done = 0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_response_data = '0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                mem_ready = 1'b1;
            end else if (!mem_request) begin
                lat_cnt = 0;
            end else if (!mem_stall) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    wb_entry_t e;
                    lat_cnt = 0;
                    mem_ready = 1'b1;
                    last_ready_cyc = cyc;
                    if (mem_write_enable) begin
                        if (exp_wr.size() == 0) check("unexpected_drain", 1, 0);
                        else begin
                            e = exp_wr.pop_front();
                            check("drain_addr", mem_address, e.addr);
                            check("drain_data", mem_write_data, e.data);
                        end
                    end else begin
                        if (exp_rd.size() == 0) check("unexpected_mem_read", 1, 0);
                        else check("mem_read_addr", mem_address, exp_rd.pop_front());
                        mem_response_data = mem_rd_value;
                    end
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] resp, input int exp_lat, input bit mem_gap);
        int k = 0;
        exp_resp.push_back(resp);
        c_write_enable = we;
        c_address = addr;
        c_write_data = data;
        c_request = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (c_ready !== 1'b1 && k < 300);
        if (c_ready !== 1'b1) begin
            check("req_timeout", 0, 1);
        end else begin
            if (exp_lat != 0) check("c_ready_latency", k, exp_lat);
            if (mem_gap) check("c_ready_after_mem_ready", cyc, last_ready_cyc + 1);
        end
        c_request = 1'b0;
    endtask

    task automatic wait_empty();
        int k = 0;
        while ((empty !== 1'b1 || mem_request !== 1'b0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drained_empty", empty, 1);
        check("all_drains_seen", exp_wr.size(), 0);
    endtask

    function automatic wb_entry_t ent(input logic [31:0] a, input logic [31:0] d);
        wb_entry_t e;
        e.valid = 1'b1;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; c_request = 1'b0; c_write_enable = 1'b0; c_address = '0;
        c_write_data = '0; flush = 1'b0; mem_stall = 1'b0; mem_lat = 2;
        mem_rd_value = '0; stray_req = 0;
        repeat (3) @(negedge clk);
        check("rst_c_ready", c_ready, 0);
        check("rst_mem_request", mem_request, 0);
        check("rst_empty", empty, 1);
        check("rst_c_response_data", c_response_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset while a drain is outstanding
        mem_stall = 1'b1;
        do_req(1'b1, 32'h200, 32'hAAAAAAAA, 32'h0, 2, 1'b0);
        n = 0;
        while (mem_request !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_started", mem_request, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_c_ready", c_ready, 0);
        check("mid_rst_c_response_data", c_response_data, 0);
        check("mid_rst_mem_request", mem_request, 0);
        check("mid_rst_mem_write_enable", mem_write_enable, 0);
        check("mid_rst_mem_address", mem_address, 0);
        check("mid_rst_mem_write_data", mem_write_data, 0);
        check("mid_rst_empty", empty, 1);
        reset = 1'b0;
        n0 = n_resp;
        stray_req++;
        repeat (5) @(negedge clk);
        check("stray_ready_mem_request", mem_request, 0);
        check("stray_ready_empty", empty, 1);
        check("stray_ready_no_c_ready", n_resp, n0);
        mem_stall = 1'b0;

        // Write then forwarded read, before the drain
        exp_wr.push_back(ent(32'h200, 32'h11111111));
        do_req(1'b1, 32'h200, 32'h11111111, 32'h0, 2, 1'b0);
        do_req(1'b0, 32'h200, 32'h0, 32'h11111111, 3, 1'b0);
        wait_empty();

        // Coalescing: one drain carrying the latest data
        exp_wr.push_back(ent(32'h300, 32'h2));
        do_req(1'b1, 32'h300, 32'h1, 32'h0, 2, 1'b0);
        do_req(1'b1, 32'h300, 32'h2, 32'h0, 3, 1'b0);
        wait_empty();

        // Read bypass around a pending write
        mem_lat = 3;
        mem_rd_value = 32'hDEADBEEF;
        exp_wr.push_back(ent(32'h400, 32'h44444444));
        exp_rd.push_back(32'h404);
        do_req(1'b1, 32'h400, 32'h44444444, 32'h0, 2, 1'b0);
        do_req(1'b0, 32'h404, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        check("bypass_before_drain", exp_wr.size(), 1);
        wait_empty();
        mem_lat = 2;

        // Full buffer with memory stalled
        mem_stall = 1'b1;
        for (int i = 0; i < 5; i++) exp_wr.push_back(ent(32'h10 + 4 * i, 32'hC0DE0000 + i));
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 32'h10 + 4 * i, 32'hC0DE0000 + i, 32'h0, (i == 0) ? 2 : 3, 1'b0);
        n0 = n_resp;
        fork
            begin
                do_req(1'b1, 32'h20, 32'hC0DE0004, 32'h0, 0, 1'b0);
                check("fifth_after_head_drain", exp_wr.size(), 4);
            end
            begin
                repeat (8) @(negedge clk);
                check("full_fifth_held", n_resp, n0);
                check("full_head_request", mem_request, 1);
                check("full_head_addr", mem_address, 32'h10);
                mem_stall = 1'b0;
            end
        join
        wait_empty();

        // Flush with three entries and a request held off
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) exp_wr.push_back(ent(32'h600 + 4 * i, 32'hF0 + i));
        for (int i = 0; i < 3; i++)
            do_req(1'b1, 32'h600 + 4 * i, 32'hF0 + i, 32'h0, (i == 0) ? 2 : 3, 1'b0);
        flush = 1'b1;
        n0 = n_resp;
        mem_rd_value = 32'h55AA55AA;
        exp_rd.push_back(32'h700);
        fork
            do_req(1'b0, 32'h700, 32'h0, 32'h55AA55AA, 0, 1'b0);
            begin
                int k = 0;
                mem_stall = 1'b0;
                @(negedge clk);
                while (empty !== 1'b1 && k < 300) begin
                    @(negedge clk);
                    k++;
                end
                check("flush_empty", empty, 1);
                check("flush_three_drains", exp_wr.size(), 0);
                check("flush_holds_request", n_resp, n0);
                flush = 1'b0;
            end
        join
        check("flush_request_served", n_resp, n0 + 1);

        repeat (4) @(negedge clk);
        check("resp_queue_drained", exp_resp.size(), 0);
        check("read_queue_drained", exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1d_write_buffer.md
Name: l1d_write_buffer

Overview:
- Write-back buffer between the L1 data cache memory port and main memory.
- Absorbs word writes from the cache (dirty evictions) into a small coalescing FIFO, so the cache does not wait on memory latency.
- Drains those writes to memory in the background.
- Serves cache reads by forwarding from the buffer on an address match, or by bypassing to memory otherwise.

Parameters:
- DEPTH, 4, number of buffered write entries (power of 2, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data word width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- c_request  in  1  cache request valid; held with fields stable until c_ready
- c_write_enable  in  1  1 = write (enqueue), 0 = read
- c_address  in  ADDR_W  word address from cache
- c_write_data  in  DATA_W  write data from cache
- c_response_data  out  DATA_W  read data to cache; valid while c_ready=1
- c_ready  out  1  one-cycle completion pulse to cache
- flush  in  1  level; while high, drain the buffer and accept no new requests
- empty  out  1  buffer holds no entries
- mem_request  out  1  memory request; held until mem_ready
- mem_write_enable  out  1  1 = drain write, 0 = read
- mem_address  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  drain data
- mem_response_data  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-transaction):
  - all entries invalid, FIFO pointers 0, state IDLE
  - c_ready=0, c_response_data=0, mem_request=0, mem_write_enable=0, mem_address=0, mem_write_data=0, empty=1
  - any in-flight memory transaction is abandoned; mem_ready while not requesting is ignored.
- States: IDLE, FWD, RD_MEM, WR_MEM, RESP. All outputs are registered.
- IDLE priority order:
  1. c_request && !flush && !c_ready → accept the cache request.
  2. Otherwise, if the buffer is non-empty → WR_MEM drain of the oldest entry.
  3. Otherwise stay in IDLE.
- A c_request seen in the same cycle that c_ready=1 is ignored; the request is consumed.
- Accepted write:
  - If the address matches a valid entry → overwrite that entry's data (coalesce; no new slot) → RESP.
  - Else if not full → enqueue at the tail → RESP.
  - Else (full, no match) → WR_MEM drain of the head. The request stays pending and is re-evaluated on return to IDLE.
- Accepted read:
  - If the address matches a valid entry → FWD, with c_response_data = that entry's data. At most one match is possible because of coalescing.
  - No match → RD_MEM.
- FWD / RESP: assert c_ready for exactly one cycle (RESP drives data 0 for writes) → IDLE.
- Latency:
  - Write accept or forwarded read: c_ready rises on the 2nd edge after c_request is first sampled.
- RD_MEM:
  - mem_request=1, mem_write_enable=0, mem_address=c_address, held until mem_ready.
  - On the mem_ready edge, latch mem_response_data → FWD-equivalent pulse next cycle.
- WR_MEM:
  - mem_request=1, mem_write_enable=1, head address and data presented, held until mem_ready.
  - On mem_ready: invalidate the head, advance the head pointer (wraps modulo DEPTH), drop mem_request → IDLE.
  - A drain once started always completes; cache requests wait.
- Reads bypass pending writes only when there is no address match, so there is no RAW hazard. Write order to memory is FIFO order of first allocation.
- empty = (count == 0), registered alongside the state update.
- flush: repeated WR_MEM drains until empty; c_request is held off (no c_ready) while flush=1.
- Simultaneous events:
  - coalescing write to the head entry while a drain of that entry is in flight cannot occur, because requests are only accepted in IDLE.
  - count is DEPTH-exact; there is no overflow or underflow path.

Decomposition:
- Package l1d_wb_pkg:
  - state enum wb_state_t
  - struct wb_entry_t {valid, addr, data}
  - localparam for pointer width ($clog2(DEPTH))
- Sub-module wb_entry_store:
  - entry array, head/tail pointers, count
  - parallel address-match vector and match index/data output
- The top level holds the FSM and both handshakes.

Test Plan:
- Reset mid-drain: write 0x200←0xAAAAAAAA, assert reset while mem_request=1 → next cycle all outputs 0, empty=1, and a later mem_ready does nothing.
- Write 0x200←0x11111111 then read 0x200 → c_ready pulse, c_response_data=0x11111111, no read mem_request issued before the drain.
- Coalesce: write 0x300←0x1, then 0x300←0x2 before the drain → exactly one drain at 0x300 with data 0x2.
- Full: DEPTH=4, memory stalled (mem_ready held low), writes to 0x10, 0x14, 0x18, 0x1C, then 0x20 →
  - 5th write gets no c_ready until 0x10 drains
  - memory sees 0x10, 0x14, 0x18, 0x1C, 0x20 in order.
- Read bypass: buffer holds 0x400, read 0x404 with mem returning 0xDEADBEEF after 3 cycles → c_ready is 1 cycle after mem_ready with 0xDEADBEEF; 0x400 drains afterwards.
- Flush with 3 entries and c_request held → 3 drains, empty=1, then the request is serviced.
